// File: rtl/pll_lock_reset_seq_pkg.sv
// pll_seq_pkg: shared FSM state encodings and width helpers for the PLL lock/reset sequencer.
package pll_seq_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/pll_lock_reset_seq_sync_bit.sv
// sync_bit: multi-flop synchronizer for a single asynchronous bit, cleared by the async reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= {q_q[STAGES-2:0], d_i};
  assign q_o = q_q[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: drives the PLL reset, qualifies lock, and releases sys_rst_n once lock has been stable.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int RETRY_W        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic               lock_fail,
  output logic [RETRY_W-1:0] retry_cnt
);
  localparam int CNT_W = clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_inc;
  logic pll_rst_q, sys_rst_n_q, ready_q, lock_lost_q, lock_fail_q, locked_s;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_locked),
    .q_o  (locked_s)
  );
  assign retry_inc = retry_q + 1'b1;
  // cnt_q is shared by all timed states and is cleared on every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      cnt_q       <= cnt_q + 1'b1;
      if (soft_rst_req) begin
        state_q     <= PLL_RST;
        cnt_q       <= '0;
        retry_q     <= '0;
        lock_fail_q <= 1'b0;
        pll_rst_q   <= 1'b1;
        sys_rst_n_q <= 1'b0;
        ready_q     <= 1'b0;
      end else begin
        case (state_q)
          PLL_RST:
            if (cnt_q == RST_LAST) begin
              state_q   <= WAIT_LOCK;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end
          WAIT_LOCK:
            if (locked_s) begin
              state_q <= STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == TO_LAST) begin
              cnt_q       <= '0;
              retry_q     <= retry_inc;
              pll_rst_q   <= 1'b1;
              state_q     <= (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
              lock_fail_q <= (retry_inc == RETRY_MAX);
            end
          STABLE:
            if (!locked_s) begin
              state_q <= WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == ST_LAST) begin
              state_q     <= RUN;
              cnt_q       <= '0;
              retry_q     <= '0;
              sys_rst_n_q <= 1'b1;
              ready_q     <= 1'b1;
            end
          RUN: begin
            cnt_q <= '0;
            if (!locked_s) begin
              state_q     <= PLL_RST;
              lock_lost_q <= 1'b1;
              pll_rst_q   <= 1'b1;
              sys_rst_n_q <= 1'b0;
              ready_q     <= 1'b0;
            end
          end
          FAIL: cnt_q <= '0;
          default: begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
          end
        endcase
      end
    end
  end
  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign lock_fail = lock_fail_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: expected output changes (cycle, vector) are queued by the stimulus and matched by a monitor.
module tb_pll_lock_reset_seq;
  logic clk = 1'b0;
  logic rst_n, pll_locked, soft_rst_req;
  logic pll_rst, sys_rst_n, ready, lock_lost, lock_fail;
  logic [2:0] retry_cnt;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int c; logic [7:0] v;} exp_t;
  exp_t q[$];
  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .MAX_RETRIES(2), .RETRY_W(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .lock_fail   (lock_fail),
    .retry_cnt   (retry_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // vector layout: {pll_rst, sys_rst_n, ready, lock_lost, lock_fail, retry_cnt[2:0]}
  task automatic ex(input int c, input logic [7:0] v);
    q.push_back('{c, v});
  endtask
  task automatic go(input int k);
    wait (cyc >= k);
    #2;
  endtask
  logic [7:0] prev = 'x;
  always @(negedge clk) begin
    logic [7:0] v;
    exp_t e;
    v = {pll_rst, sys_rst_n, ready, lock_lost, lock_fail, retry_cnt};
    if (v !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc %0d got %b", cyc, v);
      end else begin
        e = q.pop_front();
        if (v !== e.v || cyc != e.c) begin
          errors++;
          $display("FAIL out_change got %b at cyc %0d, expected %b at cyc %0d", v, cyc, e.v, e.c);
        end
      end
      prev = v;
    end
  end
  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
    ex(1, 8'b1000_0000);
    go(2);
    ex(6, 8'b0000_0000); ex(21, 8'b0110_0000);
    rst_n = 1'b1;
    go(10); pll_locked = 1'b1;
    go(25);
    ex(28, 8'b1001_0000); ex(29, 8'b1000_0000); ex(32, 8'b0000_0000); ex(45, 8'b0110_0000);
    pll_locked = 1'b0;
    go(34); pll_locked = 1'b1;
    go(50);
    ex(53, 8'b1000_0000); ex(57, 8'b0000_0000);
    pll_locked = 1'b0;
    go(52); soft_rst_req = 1'b1;
    go(53); soft_rst_req = 1'b0;
    go(58);
    ex(76, 8'b0110_0000);
    pll_locked = 1'b1;
    go(64); pll_locked = 1'b0;
    go(65); pll_locked = 1'b1;
    go(80);
    ex(83, 8'b1001_0000); ex(84, 8'b1000_0000); ex(87, 8'b0000_0000);
    ex(107, 8'b1000_0001); ex(111, 8'b0000_0001); ex(131, 8'b1000_1010);
    ex(141, 8'b1000_0000); ex(145, 8'b0000_0000);
    pll_locked = 1'b0;
    go(140); soft_rst_req = 1'b1;
    go(141); soft_rst_req = 1'b0;
    go(150);
    ex(150, 8'b1000_0000); ex(157, 8'b0000_0000);
    ex(177, 8'b1000_0001); ex(181, 8'b0000_0001); ex(192, 8'b0110_0000);
    rst_n = 1'b0;
    go(153); rst_n = 1'b1;
    go(181); pll_locked = 1'b1;
    go(205);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_changes left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
